// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority-vote bit decisions, configurable
// frame format, framing/parity/overrun reporting and a show-ahead receive FIFO.
module uart_rx_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_100,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 fifo_full,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 led_rx
);
    localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int H   = OVERSAMPLE / 2;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic                 r_rx_d;
    logic [DW-1:0]        r_div;
    logic [TW-1:0]        r_tcnt;
    logic [3:0]           r_bcnt;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_fbad, r_wr;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [AW:0]          r_cnt;

    logic          w_rx, w_tick, w_vstb, w_bend, w_vote, w_fbad;
    logic          w_pop, w_full, w_push;
    logic [AW-1:0] w_nrp;
    logic [AW:0]   w_ncnt;

    assign w_rx   = r_sync[1];
    assign w_tick = r_div == DW'(DIV - 1);
    assign w_vstb = w_tick && r_tcnt == TW'(H + 1);
    assign w_bend = w_tick && r_tcnt == TW'(OVERSAMPLE - 1);
    assign w_vote = (r_s0 & r_s1) | (w_rx & (r_s0 | r_s1));
    assign w_fbad = r_fbad | ~w_vote;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sync     <= 2'b11;
            r_rx_d     <= 1'b1;
            r_div      <= '0;
            r_tcnt     <= '0;
            r_bcnt     <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_fbad     <= 1'b0;
            r_wr       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_rx_d     <= w_rx;
            r_wr       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            r_div      <= (r_state == S_IDLE || w_tick) ? '0 : r_div + 1'b1;
            if (w_tick) r_tcnt <= w_bend ? '0 : r_tcnt + 1'b1;
            if (w_tick && r_tcnt == TW'(H - 1)) r_s0 <= w_rx;
            if (w_tick && r_tcnt == TW'(H)) r_s1 <= w_rx;
            case (r_state)
                S_IDLE: if (r_rx_d && !w_rx) begin
                    r_state <= S_START;
                    r_tcnt  <= '0;
                    r_fbad  <= 1'b0;
                end
                S_START: if (w_vstb && w_vote) r_state <= S_IDLE;
                    else if (w_bend) begin
                        r_state <= S_DATA;
                        r_bcnt  <= '0;
                    end
                S_DATA: begin
                    if (w_vstb) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_bend) begin
                        r_bcnt <= (r_bcnt == 4'(DATA_BITS - 1)) ? '0 : r_bcnt + 1'b1;
                        if (r_bcnt == 4'(DATA_BITS - 1)) r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (w_vstb) r_perr <= w_vote ^ (^r_shift) ^ (PARITY == 2);
                    if (w_bend) r_state <= S_STOP;
                end
                // The last stop-bit vote ends the frame at mid-bit so a new start edge can follow.
                S_STOP: if (w_vstb) begin
                    if (r_bcnt == 4'(STOP_BITS - 1)) begin
                        r_state    <= w_fbad ? S_BREAK : S_IDLE;
                        frame_err  <= w_fbad;
                        parity_err <= !w_fbad && r_perr;
                        r_wr       <= !w_fbad && !r_perr;
                    end else r_fbad <= w_fbad;
                end else if (w_bend) r_bcnt <= r_bcnt + 1'b1;
                S_BREAK: if (w_rx) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop  = rd_en && r_cnt != '0;
    assign w_full = r_cnt == (AW + 1)'(FIFO_DEPTH);
    assign w_push = r_wr && (!w_full || w_pop);
    assign w_nrp  = r_rp + AW'(w_pop);
    assign w_ncnt = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    always_ff @(posedge clk_100) begin
        if (w_push) r_mem[r_wp] <= r_shift;
    end

    // rd_data is registered from the post-update head, bypassing a word written into it.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            rd_data <= '0;
            overrun <= 1'b0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= w_nrp;
            r_cnt   <= w_ncnt;
            overrun <= r_wr && w_full && !w_pop;
            rd_data <= (w_ncnt == '0) ? '0 : (w_push && w_nrp == r_wp) ? r_shift : r_mem[w_nrp];
        end
    end

    assign rd_valid  = r_cnt != '0;
    assign fifo_full = w_full;
    assign led_rx    = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: two receivers (8N1 and 8E2) driven with directed, table and random frames,
// checked against a queue-based model of the receive FIFO and error counters.
module tb_uart_rx_param;
    localparam int BT = 32;

    logic clk = 0, rst_n = 0, rx0 = 1, rx1 = 1, rd_en0 = 0, rd_en1 = 0;
    logic [7:0] rd_data0, rd_data1;
    logic rd_valid0, fifo_full0, frame_err0, parity_err0, overrun0, led_rx0;
    logic rd_valid1, fifo_full1, frame_err1, parity_err1, overrun1, led_rx1;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(100_000_000), .BAUD(3_125_000), .OVERSAMPLE(8), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk_100(clk), .rst_n(rst_n), .rx(rx0), .rd_en(rd_en0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .fifo_full(fifo_full0), .frame_err(frame_err0),
        .parity_err(parity_err0), .overrun(overrun0), .led_rx(led_rx0));

    uart_rx_param #(.CLK_HZ(100_000_000), .BAUD(3_125_000), .OVERSAMPLE(8), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clk_100(clk), .rst_n(rst_n), .rx(rx1), .rd_en(rd_en1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .fifo_full(fifo_full1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overrun(overrun1), .led_rx(led_rx1));

    int total = 0, bad = 0;
    int nfe0 = 0, npe0 = 0, nov0 = 0, nfe1 = 0, npe1 = 0, nov1 = 0;
    int efe0 = 0, epe0 = 0, eov0 = 0, efe1 = 0, epe1 = 0, eov1 = 0;
    logic [7:0] q0[$], q1[$];

    always @(posedge clk) begin
        if (frame_err0) nfe0++;
        if (parity_err0) npe0++;
        if (overrun0) nov0++;
        if (frame_err1) nfe1++;
        if (parity_err1) npe1++;
        if (overrun1) nov1++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic status(input string nm);
        chk({nm, " frame_err0 count"}, nfe0, efe0);
        chk({nm, " parity_err0 count"}, npe0, epe0);
        chk({nm, " overrun0 count"}, nov0, eov0);
        chk({nm, " frame_err1 count"}, nfe1, efe1);
        chk({nm, " parity_err1 count"}, npe1, epe1);
        chk({nm, " overrun1 count"}, nov1, eov1);
    endtask

    task automatic occ(input string nm);
        chk({nm, " rd_valid0"}, rd_valid0, q0.size() != 0);
        chk({nm, " fifo_full0"}, fifo_full0, q0.size() == 4);
        chk({nm, " rd_valid1"}, rd_valid1, q1.size() != 0);
        chk({nm, " fifo_full1"}, fifo_full1, q1.size() == 4);
    endtask

    task automatic send(input bit ch, input logic [11:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch) rx1 = b[i]; else rx0 = b[i];
            repeat (BT) @(negedge clk);
        end
    endtask

    // Model: a bad stop bit wins over parity; a good word is kept only if the FIFO has room.
    task automatic model(input bit ch, input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (!stop_ok) begin
            if (ch) efe1++; else efe0++;
        end else if (!par_ok) begin
            if (ch) epe1++; else epe0++;
        end else if (ch) begin
            if (q1.size() == 4) eov1++; else q1.push_back(d);
        end else begin
            if (q0.size() == 4) eov0++; else q0.push_back(d);
        end
    endtask

    task automatic frame(input bit ch, input logic [7:0] d, input bit stop_ok, input bit par_ok,
                         input int gap);
        if (ch) send(1, {stop_ok, stop_ok, (^d) ^ !par_ok, d, 1'b0}, 12);
        else send(0, {2'b11, stop_ok, d, 1'b0}, 10);
        if (!stop_ok) begin
            repeat (BT) @(negedge clk);
            if (ch) rx1 = 1; else rx0 = 1;
            repeat (BT) @(negedge clk);
        end
        model(ch, d, stop_ok, par_ok);
        repeat (gap) @(negedge clk);
    endtask

    task automatic pop(input bit ch, input string nm);
        logic [7:0] e;
        if (ch) begin
            e = q1.pop_front();
            chk({nm, " rd_valid1"}, rd_valid1, 1);
            chk({nm, " rd_data1"}, rd_data1, e);
            rd_en1 = 1;
            @(negedge clk);
            rd_en1 = 0;
        end else begin
            e = q0.pop_front();
            chk({nm, " rd_valid0"}, rd_valid0, 1);
            chk({nm, " rd_data0"}, rd_data0, e);
            rd_en0 = 1;
            @(negedge clk);
            rd_en0 = 0;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int fe_before, npop;
        bit ch, stop_ok, par_ok;
        logic [7:0] d;
        tbl[0] = '{8'h0F, 1, 1, 8'h0F, 0};
        tbl[1] = '{8'h55, 1, 1, 8'h55, 0};
        tbl[2] = '{8'hAA, 1, 1, 8'hAA, 0};
        tbl[3] = '{8'h00, 0, 0, 8'h00, 1};
        tbl[4] = '{8'hFF, 1, 1, 8'hFF, 0};
        tbl[5] = '{8'h80, 1, 1, 8'h80, 0};
        tbl[6] = '{8'h3C, 0, 0, 8'h00, 1};

        repeat (3) @(negedge clk);
        chk("reset rd_valid0", rd_valid0, 0);
        chk("reset rd_data0", rd_data0, 0);
        chk("reset fifo_full0", fifo_full0, 0);
        chk("reset led_rx0", led_rx0, 0);
        chk("reset errs0", {frame_err0, parity_err0, overrun0}, 0);
        chk("reset rd_data1", rd_data1, 0);
        chk("reset led_rx1", led_rx1, 0);
        rst_n = 1;
        repeat (BT) @(negedge clk);

        frame(0, 8'h0F, 1, 1, 4);
        chk("t1 led_rx0 after stop", led_rx0, 0);
        chk("t1 rd_data0", rd_data0, 8'h0F);
        pop(0, "t1");
        status("t1");

        frame(0, 8'h0F, 1, 1, 0);
        frame(0, 8'hFF, 1, 1, 4);
        occ("t2");
        pop(0, "t2 first");
        pop(0, "t2 second");
        chk("t2 empty rd_valid0", rd_valid0, 0);
        status("t2");

        foreach (tbl[i]) begin
            fe_before = nfe0;
            frame(0, tbl[i].d, tbl[i].stop_ok, 1, 4);
            chk($sformatf("tbl%0d rd_valid0", i), rd_valid0, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d rd_data0", i), rd_data0, tbl[i].exp_data);
                pop(0, $sformatf("tbl%0d", i));
            end
            chk($sformatf("tbl%0d frame_err0 pulses", i), nfe0 - fe_before, tbl[i].exp_fe);
        end
        status("tbl");

        send(0, 12'h000, 10);
        for (int i = 0; i < 3; i++) begin
            repeat (BT) @(negedge clk);
            chk($sformatf("t3 led_rx0 break %0d", i), led_rx0, 1);
        end
        efe0++;
        rx0 = 1;
        repeat (4) @(negedge clk);
        chk("t3 led_rx0 after break", led_rx0, 0);
        chk("t3 rd_valid0", rd_valid0, 0);
        status("t3");

        rx0 = 0;
        repeat (6) @(negedge clk);
        chk("t4 led_rx0 during glitch", led_rx0, 1);
        repeat (2) @(negedge clk);
        rx0 = 1;
        repeat (2 * BT) @(negedge clk);
        chk("t4 led_rx0 idle", led_rx0, 0);
        chk("t4 rd_valid0", rd_valid0, 0);
        status("t4");

        for (int i = 1; i <= 5; i++) begin
            frame(0, 8'(i), 1, 1, 4);
            occ($sformatf("t5a word%0d", i));
        end
        status("t5a");
        for (int i = 0; i < 4; i++) pop(0, $sformatf("t5a pop%0d", i));
        chk("t5a drained", rd_valid0, 0);

        for (int i = 1; i <= 4; i++) frame(0, 8'(i), 1, 1, 4);
        fork
            send(0, {2'b11, 1'b1, 8'h05, 1'b0}, 10);
            begin
                repeat (9 * BT + 27) @(negedge clk);
                rd_en0 = 1;
                @(negedge clk);
                rd_en0 = 0;
            end
        join
        void'(q0.pop_front());
        q0.push_back(8'h05);
        repeat (4) @(negedge clk);
        occ("t5b");
        status("t5b");
        for (int i = 0; i < 4; i++) pop(0, $sformatf("t5b pop%0d", i));
        chk("t5b drained", rd_valid0, 0);

        frame(1, 8'h07, 1, 0, 4);
        chk("t6 bad parity rd_valid1", rd_valid1, 0);
        status("t6 bad parity");
        frame(1, 8'h07, 1, 1, 4);
        chk("t6 good parity rd_data1", rd_data1, 8'h07);
        pop(1, "t6 good parity");
        status("t6 good parity");

        for (int i = 0; i < 16; i++) begin
            ch      = 1'($urandom_range(0, 1));
            d       = 8'($urandom);
            stop_ok = $urandom_range(0, 7) != 0;
            par_ok  = ch ? ($urandom_range(0, 3) != 0) : 1'b1;
            frame(ch, d, stop_ok, par_ok, 4);
            occ($sformatf("rnd%0d", i));
            status($sformatf("rnd%0d", i));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                if (q0.size() != 0) pop(0, $sformatf("rnd%0d pop", i));
                if (q1.size() != 0) pop(1, $sformatf("rnd%0d pop", i));
            end
        end

        rx1 = 0;
        repeat (BT) @(negedge clk);
        rx1 = 1;
        repeat (BT) @(negedge clk);
        rx1 = 0;
        repeat (BT / 2) @(negedge clk);
        chk("t6 led_rx1 mid data", led_rx1, 1);
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("t6 reset outputs1", {rd_data1, rd_valid1, fifo_full1, frame_err1, parity_err1,
                                  overrun1, led_rx1}, 0);
        chk("t6 reset outputs0", {rd_data0, rd_valid0, fifo_full0, led_rx0}, 0);
        rx1 = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        q0.delete();
        q1.delete();
        repeat (BT) @(negedge clk);
        chk("t6 led_rx1 after reset", led_rx1, 0);
        frame(1, 8'h0F, 1, 1, 4);
        chk("t6 post-reset rd_data1", rd_data1, 8'h0F);
        pop(1, "t6 post-reset");
        occ("final");
        status("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
